// File: rtl/cpu_pkg.sv
// cpu_pkg: shared integer-pipeline constants and register-file types
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int CNT_W = 64;
  localparam logic [AW-1:0] ZERO_REG = '0;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREG x XLEN storage, one write port, two combinational read ports, x0 reads zero
module regfile_2r1w
  import cpu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  xword_t    wdata_i,
  input  reg_addr_t raddr1_i,
  input  reg_addr_t raddr2_i,
  output xword_t    rdata1_o,
  output xword_t    rdata2_o
);
  xword_t mem [NREG];
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we_i && waddr_i != ZERO_REG)
      mem[waddr_i] <= wdata_i;
  assign rdata1_o = (raddr1_i == ZERO_REG) ? '0 : mem[raddr1_i];
  assign rdata2_o = (raddr2_i == ZERO_REG) ? '0 : mem[raddr2_i];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, register-file write qualification and retired-instruction counter
// Define WB_REGFILE_BYPASS_EN for write-first forwarding of WBdata_o onto matching read ports.
module wb_regfile
  import cpu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             Valid_i,
  input  logic             RegWrite_i,
  input  logic             Mem2Reg_i,
  input  xword_t           ReadData_i,
  input  xword_t           ALU_data_i,
  input  reg_addr_t        RDaddr_i,
  input  reg_addr_t        RS1addr_i,
  input  reg_addr_t        RS2addr_i,
  output xword_t           RS1data_o,
  output xword_t           RS2data_o,
  output logic             WBen_o,
  output reg_addr_t        WBaddr_o,
  output xword_t           WBdata_o,
  output logic [CNT_W-1:0] Instret_o
);
  xword_t rd1, rd2;
  logic [CNT_W-1:0] instret_q;
  assign WBen_o = Valid_i & RegWrite_i & (RDaddr_i != ZERO_REG);
  assign WBaddr_o = RDaddr_i;
  assign WBdata_o = Mem2Reg_i ? ReadData_i : ALU_data_i;
  regfile_2r1w u_rf (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (WBen_o),
    .waddr_i  (RDaddr_i),
    .wdata_i  (WBdata_o),
    .raddr1_i (RS1addr_i),
    .raddr2_i (RS2addr_i),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );
`ifdef WB_REGFILE_BYPASS_EN
  assign RS1data_o = (WBen_o && RS1addr_i == RDaddr_i) ? WBdata_o : rd1;
  assign RS2data_o = (WBen_o && RS2addr_i == RDaddr_i) ? WBdata_o : rd2;
`else
  assign RS1data_o = rd1;
  assign RS2data_o = rd2;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) instret_q <= '0;
    else if (Valid_i) instret_q <= instret_q + 1'b1;
  assign Instret_o = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of writeback, x0, bubbles, hazard read, reset and counter wrap
module tb_wb_regfile;
  import cpu_pkg::*;
  logic clk_i = 0, rst_n_i = 0;
  logic Valid_i = 0, RegWrite_i = 0, Mem2Reg_i = 0;
  xword_t ReadData_i = '0, ALU_data_i = '0;
  reg_addr_t RDaddr_i = '0, RS1addr_i = '0, RS2addr_i = '0;
  xword_t RS1data_o, RS2data_o, WBdata_o;
  logic WBen_o;
  reg_addr_t WBaddr_o;
  logic [CNT_W-1:0] Instret_o;
  int errors = 0, checks = 0;

  wb_regfile dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .Valid_i(Valid_i), .RegWrite_i(RegWrite_i),
    .Mem2Reg_i(Mem2Reg_i), .ReadData_i(ReadData_i), .ALU_data_i(ALU_data_i),
    .RDaddr_i(RDaddr_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .WBen_o(WBen_o),
    .WBaddr_o(WBaddr_o), .WBdata_o(WBdata_o), .Instret_o(Instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input logic v, input logic rw, input logic m2r, input xword_t rdat,
                    input xword_t alu, input reg_addr_t rd);
    Valid_i = v; RegWrite_i = rw; Mem2Reg_i = m2r;
    ReadData_i = rdat; ALU_data_i = alu; RDaddr_i = rd;
  endtask

  initial begin
    step(); step();
    RS1addr_i = 5;
    #1;
    chk("reset_rs1", RS1data_o, 0);
    chk("reset_instret", Instret_o, 0);
    rst_n_i = 1;
    wb(1, 1, 0, 32'h0, 32'h1234, 5);
    #1;
    chk("alu_wben", WBen_o, 1);
    chk("alu_wbaddr", WBaddr_o, 5);
    chk("alu_wbdata", WBdata_o, 32'h1234);
    step();
    wb(0, 0, 0, 0, 0, 0);
    #1;
    chk("alu_read", RS1data_o, 32'h1234);
    chk("instret_1", Instret_o, 1);
    wb(1, 1, 1, 32'hDEADBEEF, 32'h1111, 6);
    #1;
    chk("mem_wbdata", WBdata_o, 32'hDEADBEEF);
    step();
    wb(0, 0, 0, 0, 0, 0);
    RS2addr_i = 6;
    #1;
    chk("mem_read", RS2data_o, 32'hDEADBEEF);
    chk("rs1_kept", RS1data_o, 32'h1234);
    chk("instret_2", Instret_o, 2);
    wb(1, 1, 0, 0, 32'hFFFFFFFF, 0);
    #1;
    chk("x0_wben", WBen_o, 0);
    step();
    wb(0, 0, 0, 0, 0, 0);
    RS2addr_i = 0;
    #1;
    chk("x0_read", RS2data_o, 0);
    chk("instret_3", Instret_o, 3);
    wb(0, 1, 0, 0, 32'h55, 7);
    RS1addr_i = 7;
    #1;
    chk("bubble_wben", WBen_o, 0);
    step();
    wb(0, 0, 0, 0, 0, 0);
    #1;
    chk("bubble_reg7", RS1data_o, 0);
    chk("bubble_instret", Instret_o, 3);
    wb(1, 1, 0, 0, 32'h1, 9);
    step();
    wb(1, 1, 0, 0, 32'h2, 9);
    RS1addr_i = 9; RS2addr_i = 9;
    #1;
    chk("instret_4", Instret_o, 4);
`ifdef WB_REGFILE_BYPASS_EN
    chk("hazard_rs1", RS1data_o, 32'h2);
    chk("hazard_rs2", RS2data_o, 32'h2);
`else
    chk("hazard_rs1", RS1data_o, 32'h1);
    chk("hazard_rs2", RS2data_o, 32'h1);
`endif
    step();
    wb(0, 0, 0, 0, 0, 0);
    #1;
    chk("hazard_next", RS1data_o, 32'h2);
    chk("instret_5", Instret_o, 5);
    #2;
    rst_n_i = 0;
    #1;
    chk("async_rs1", RS1data_o, 0);
    chk("async_instret", Instret_o, 0);
    wb(1, 1, 0, 0, 32'h77, 10);
    step();
    wb(0, 0, 0, 0, 0, 0);
    rst_n_i = 1;
    RS1addr_i = 10;
    #1;
    chk("rst_wins_reg10", RS1data_o, 0);
    chk("rst_wins_instret", Instret_o, 0);
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    #1;
    chk("preload_instret", Instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    Valid_i = 1;
    step();
    Valid_i = 0;
    #1;
    chk("wrap_instret", Instret_o, 0);
    Valid_i = 1;
    for (int i = 0; i < 10; i++) step();
    Valid_i = 0;
    #1;
    chk("count_10", Instret_o, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
